axilite_slave_test: RTL and testbench
=====================================

# axilite_slave_test

Synthesizable AXI4-Lite slave test responder: the target-side counterpart of the AXI-Lite write test generator used to exercise the NoC/AXI-Lite bridge. It accepts AW/W beats with programmable backpressure, checks them against an expected incrementing address/data sequence, returns B responses, and answers AR with deterministic R data. It reports pass/fail through counters and a sticky error flag.

## Interface
- AXILITE_ADDR_WIDTH, 48, address width
- AXILITE_DATA_WIDTH, 64, data width (must be >= AXILITE_ADDR_WIDTH)
- EXP_ADDR_INIT, 48'h0000_2000_0000, first expected write address
- EXP_DATA_INIT, 64'h0, first expected write data
- STALL_PERIOD, 4, every STALL_PERIOD cycles the block forces one cycle of ready deassertion; 0 disables stalling

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- s_axi_awaddr  in  ADDR_W  write address
- s_axi_awvalid  in  1
- s_axi_awready  out  1
- s_axi_wdata  in  DATA_W  write data
- s_axi_wvalid  in  1
- s_axi_wready  out  1
- s_axi_bresp  out  2  2'b00 OKAY, or 2'b10 SLVERR on mismatch
- s_axi_bvalid  out  1
- s_axi_bready  in  1
- s_axi_araddr  in  ADDR_W
- s_axi_arvalid  in  1
- s_axi_arready  out  1
- s_axi_rdata  out  DATA_W  araddr zero-extended
- s_axi_rresp  out  2  always 2'b00
- s_axi_rvalid  out  1
- s_axi_rready  in  1
- write_count  out  32  committed writes, wraps at 2^32
- error_count  out  16  mismatched writes, saturates at 16'hFFFF
- error_flag  out  1  sticky; set on the first mismatch

## Operation
- stall_cnt is a free-running counter, 0..STALL_PERIOD-1.
  - stall = (STALL_PERIOD != 0) && (stall_cnt == STALL_PERIOD-1).
- AW holding register (aw_full, aw_q) and W holding register (w_full, w_q) are one deep each.
  - awready = !aw_full && !stall; wready = !w_full && !stall.
  - AW and W are accepted independently, in any order or in the same cycle.
- Commit happens in a cycle where aw_full && w_full && (!bvalid || bready). At that edge:
  - compare aw_q against exp_addr and w_q against exp_data;
  - bvalid <= 1; bresp <= 2'b00 if both match, else 2'b10;
  - clear aw_full and w_full;
  - exp_addr and exp_data each increment by 1, wrapping modulo their widths;
  - write_count increments;
  - on mismatch, error_count increments (saturating) and error_flag is set.
- The expected sequence always advances on commit, whether or not the beat matched, so one bad beat produces exactly one error.
- bvalid clears on bvalid && bready unless a new commit happens at the same edge, in which case it stays 1 with the new bresp.
- Read path:
  - arready = !rvalid && !stall.
  - On an AR handshake: rvalid <= 1, rdata <= zero-extended araddr, rresp <= 00.
  - rvalid clears on rready.
  - The read path is independent of the write path.
- Reset values: awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=0, rdata=0, rresp=0, write_count=0, error_count=0, error_flag=0, holding registers empty, exp_* = INIT, stall_cnt=0.
  - Ready outputs are 0 during rst and follow the equations from the first cycle after rst deasserts.
- Reset mid-operation discards held beats and any pending B/R response; the next write is checked against EXP_*_INIT.

## Timing
- AW and W handshakes complete in cycle N.
  - The holding registers are full in N+1; commit is evaluated in N+1.
  - bvalid is high in N+2 at the earliest.
- Ready is deasserted while a holding register is full, so sustained write throughput is at most one write per 2 cycles, less during stall cycles.
- AR handshake in cycle N gives rvalid in N+1; a new AR can be accepted in the cycle after the R handshake.
- A held B (bready=0) blocks commit; AW/W stay full, so their ready outputs stay low. This is backpressure, not loss.
- Ready outputs never depend combinationally on valid inputs.
- All outputs are registered except the ready outputs, which combine registered state with stall.

## Test plan
- Reset, then 8 writes with addr=0x2000_0000+i, data=i, bready=1, STALL_PERIOD=4 -> 8 B responses with bresp=00, write_count=8, error_count=0, and awready=0 every 4th cycle.
- AW sent 3 cycles before W, then W before AW -> each write commits one cycle after the later beat and gives bresp=00.
- Hold bready=0 for 10 cycles after the first write -> bvalid stays 1 with stable bresp, the second write is held, awready and wready stay 0, and nothing is dropped after bready rises.
- Third write with data=0xDEAD -> that write gets bresp=10, error_flag=1, error_count=1; the fourth write (addr+3, data=3) gets bresp=00.
- AR addr=0x1234 with rready low for 5 cycles -> rvalid held, rdata=0x1234, arready=0; a simultaneous write completes normally.
- Assert rst while AW is held and B is pending -> next cycle all valids=0 and counters=0; the next write at 0x2000_0000 with data 0 gets bresp=00.

Source files
------------

// File: rtl/axilite_slave_test_if.sv
// AXI4-Lite bus bundle for the slave test responder.
// Master drives requests; slave drives ready/response.
interface axilite_slave_test_if #(
    parameter int ADDR_W = 48,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] s_axi_awaddr;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [DATA_W-1:0] s_axi_wdata;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid,
        output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid,
        input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/axilite_slave_test.sv
// AXI4-Lite test responder: checks an incrementing write sequence,
// injects periodic ready stalls and echoes the read address as data.
module axilite_slave_test #(
    parameter int                          AXILITE_ADDR_WIDTH = 48,
    parameter int                          AXILITE_DATA_WIDTH = 64,
    parameter logic [AXILITE_ADDR_WIDTH-1:0] EXP_ADDR_INIT      = 48'h0000_2000_0000,
    parameter logic [AXILITE_DATA_WIDTH-1:0] EXP_DATA_INIT      = 64'h0,
    parameter int                          STALL_PERIOD       = 4
) (
    input  logic                clk,
    input  logic                rst,
    axilite_slave_test_if.slave axi,
    output logic [31:0]         write_count,
    output logic [15:0]         error_count,
    output logic                error_flag
);
    localparam int AW = AXILITE_ADDR_WIDTH;
    localparam int DW = AXILITE_DATA_WIDTH;
    localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    logic [SW-1:0] stall_cnt_q, stall_cnt_d;
    logic          stall;

    logic          aw_full_q, aw_full_d;
    logic [AW-1:0] aw_q, aw_d;
    logic          w_full_q, w_full_d;
    logic [DW-1:0] w_q, w_d;
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic [AW-1:0] exp_addr_q, exp_addr_d;
    logic [DW-1:0] exp_data_q, exp_data_d;
    logic [31:0]   wcnt_q, wcnt_d;
    logic [15:0]   ecnt_q, ecnt_d;
    logic          eflag_q, eflag_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic aw_hs, w_hs, ar_hs, commit, mismatch;

    assign stall = (STALL_PERIOD != 0) && (stall_cnt_q == SW'(STALL_PERIOD - 1));

    // Readies are held low through reset, then follow state and stall only
    assign axi.s_axi_awready = !rst && !aw_full_q && !stall;
    assign axi.s_axi_wready  = !rst && !w_full_q && !stall;
    assign axi.s_axi_arready = !rst && !rvalid_q && !stall;

    assign aw_hs    = axi.s_axi_awvalid && axi.s_axi_awready;
    assign w_hs     = axi.s_axi_wvalid && axi.s_axi_wready;
    assign ar_hs    = axi.s_axi_arvalid && axi.s_axi_arready;
    assign commit   = aw_full_q && w_full_q && (!bvalid_q || axi.s_axi_bready);
    assign mismatch = (aw_q != exp_addr_q) || (w_q != exp_data_q);

    always_comb begin
        stall_cnt_d = (STALL_PERIOD == 0 || stall) ? '0 : stall_cnt_q + 1'b1;

        aw_full_d = aw_hs ? 1'b1 : (commit ? 1'b0 : aw_full_q);
        aw_d      = aw_hs ? axi.s_axi_awaddr : aw_q;
        w_full_d  = w_hs ? 1'b1 : (commit ? 1'b0 : w_full_q);
        w_d       = w_hs ? axi.s_axi_wdata : w_q;

        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        exp_addr_d = exp_addr_q;
        exp_data_d = exp_data_q;
        wcnt_d     = wcnt_q;
        ecnt_d     = ecnt_q;
        eflag_d    = eflag_q;

        if (bvalid_q && axi.s_axi_bready) bvalid_d = 1'b0;

        // Expected sequence advances on every commit, good or bad
        if (commit) begin
            bvalid_d   = 1'b1;
            bresp_d    = mismatch ? 2'b10 : 2'b00;
            exp_addr_d = exp_addr_q + 1'b1;
            exp_data_d = exp_data_q + 1'b1;
            wcnt_d     = wcnt_q + 32'd1;
            if (mismatch) begin
                eflag_d = 1'b1;
                if (ecnt_q != 16'hFFFF) ecnt_d = ecnt_q + 16'd1;
            end
        end

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (rvalid_q && axi.s_axi_rready) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = DW'(axi.s_axi_araddr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            aw_full_q   <= 1'b0;
            aw_q        <= '0;
            w_full_q    <= 1'b0;
            w_q         <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= 2'b00;
            exp_addr_q  <= EXP_ADDR_INIT;
            exp_data_q  <= EXP_DATA_INIT;
            wcnt_q      <= '0;
            ecnt_q      <= '0;
            eflag_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            aw_full_q   <= aw_full_d;
            aw_q        <= aw_d;
            w_full_q    <= w_full_d;
            w_q         <= w_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            exp_addr_q  <= exp_addr_d;
            exp_data_q  <= exp_data_d;
            wcnt_q      <= wcnt_d;
            ecnt_q      <= ecnt_d;
            eflag_q     <= eflag_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign axi.s_axi_bvalid = bvalid_q;
    assign axi.s_axi_bresp  = bresp_q;
    assign axi.s_axi_rvalid = rvalid_q;
    assign axi.s_axi_rdata  = rdata_q;
    assign axi.s_axi_rresp  = 2'b00;
    assign write_count      = wcnt_q;
    assign error_count      = ecnt_q;
    assign error_flag       = eflag_q;
endmodule

// File: tb/tb_axilite_slave_test.sv
// Directed bench for axilite_slave_test: write sequence, ordering,
// B backpressure, error injection, reads and mid-run reset.
module tb_axilite_slave_test;
    localparam logic [47:0] BASE = 48'h0000_2000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] write_count;
    logic [15:0] error_count;
    logic        error_flag;
    int          n_chk;
    int          n_fail;

    axilite_slave_test_if #(.ADDR_W(48), .DATA_W(64)) bus ();

    axilite_slave_test #(
        .AXILITE_ADDR_WIDTH (48),
        .AXILITE_DATA_WIDTH (64),
        .EXP_ADDR_INIT      (BASE),
        .EXP_DATA_INIT      (64'h0),
        .STALL_PERIOD       (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .axi         (bus),
        .write_count (write_count),
        .error_count (error_count),
        .error_flag  (error_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_chk++;
        n_fail++;
        $error("FAIL %s: timeout observed no handshake expected handshake", tag);
    endtask

    // Starts and ends just after a rising edge
    task automatic send(input string tag, input bit do_aw, input bit do_w,
                        input logic [47:0] a, input logic [63:0] d);
        bit aw_pend = do_aw;
        bit w_pend  = do_w;
        bit ahs, whs;
        int n = 0;
        bus.s_axi_awaddr  = a;
        bus.s_axi_awvalid = do_aw;
        bus.s_axi_wdata   = d;
        bus.s_axi_wvalid  = do_w;
        while ((aw_pend || w_pend) && n < 50) begin
            @(negedge clk);
            ahs = bus.s_axi_awvalid && bus.s_axi_awready;
            whs = bus.s_axi_wvalid && bus.s_axi_wready;
            @(posedge clk);
            #1;
            if (ahs) begin bus.s_axi_awvalid = 1'b0; aw_pend = 1'b0; end
            if (whs) begin bus.s_axi_wvalid = 1'b0; w_pend = 1'b0; end
            n++;
        end
        if (aw_pend || w_pend) begin
            timeout(tag);
            bus.s_axi_awvalid = 1'b0;
            bus.s_axi_wvalid  = 1'b0;
        end
    endtask

    task automatic wait_b(input string tag, input logic [1:0] exp);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.s_axi_bvalid && n < 40);
        if (!bus.s_axi_bvalid) timeout(tag);
        else chk(tag, 64'(bus.s_axi_bresp), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.s_axi_awaddr  = '0;
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata   = '0;
        bus.s_axi_wvalid  = 1'b0;
        bus.s_axi_bready  = 1'b1;
        bus.s_axi_araddr  = '0;
        bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 64'(bus.s_axi_awready), 64'd0);
        chk("rst_wready", 64'(bus.s_axi_wready), 64'd0);
        chk("rst_arready", 64'(bus.s_axi_arready), 64'd0);
        chk("rst_bvalid", 64'(bus.s_axi_bvalid), 64'd0);
        chk("rst_rvalid", 64'(bus.s_axi_rvalid), 64'd0);
        chk("rst_bresp", 64'(bus.s_axi_bresp), 64'd0);
        chk("rst_rdata", bus.s_axi_rdata, 64'd0);
        chk("rst_wcount", 64'(write_count), 64'd0);
        chk("rst_ecount", 64'(error_count), 64'd0);
        chk("rst_eflag", 64'(error_flag), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Stall pattern: ready drops in every 4th cycle after reset
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("stall_aw_%0d", k), 64'(bus.s_axi_awready), 64'((k % 4) != 3));
            chk($sformatf("stall_w_%0d", k), 64'(bus.s_axi_wready), 64'((k % 4) != 3));
        end
        @(posedge clk);
        #1;

        // Eight in-order writes
        for (int i = 0; i < 8; i++) begin
            send("seq_w", 1'b1, 1'b1, BASE + 48'(i), 64'(i));
            wait_b($sformatf("seq_b_%0d", i), 2'b00);
        end
        chk("seq_wcount", 64'(write_count), 64'd8);
        chk("seq_ecount", 64'(error_count), 64'd0);

        // AW three cycles before W
        send("aw_first_aw", 1'b1, 1'b0, BASE + 48'd8, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        send("aw_first_w", 1'b0, 1'b1, 48'd0, 64'd8);
        @(negedge clk);
        chk("aw_first_b_early", 64'(bus.s_axi_bvalid), 64'd0);
        @(negedge clk);
        chk("aw_first_bvalid", 64'(bus.s_axi_bvalid), 64'd1);
        chk("aw_first_bresp", 64'(bus.s_axi_bresp), 64'd0);
        @(posedge clk);
        #1;

        // W three cycles before AW
        send("w_first_w", 1'b0, 1'b1, 48'd0, 64'd9);
        repeat (3) @(posedge clk);
        #1;
        send("w_first_aw", 1'b1, 1'b0, BASE + 48'd9, 64'd0);
        @(negedge clk);
        chk("w_first_b_early", 64'(bus.s_axi_bvalid), 64'd0);
        @(negedge clk);
        chk("w_first_bvalid", 64'(bus.s_axi_bvalid), 64'd1);
        chk("w_first_bresp", 64'(bus.s_axi_bresp), 64'd0);
        @(posedge clk);
        #1;

        // B held off: second write is parked, readies stay low
        bus.s_axi_bready = 1'b0;
        send("hold_w1", 1'b1, 1'b1, BASE + 48'd10, 64'd10);
        wait_b("hold_b1", 2'b00);
        send("hold_w2", 1'b1, 1'b1, BASE + 48'd11, 64'd11);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_bvalid", 64'(bus.s_axi_bvalid), 64'd1);
            chk("hold_bresp", 64'(bus.s_axi_bresp), 64'd0);
            chk("hold_awready", 64'(bus.s_axi_awready), 64'd0);
            chk("hold_wready", 64'(bus.s_axi_wready), 64'd0);
        end
        chk("hold_wcount", 64'(write_count), 64'd11);
        @(posedge clk);
        #1 bus.s_axi_bready = 1'b1;
        wait_b("hold_b1_release", 2'b00);
        wait_b("hold_b2", 2'b00);
        chk("hold_wcount2", 64'(write_count), 64'd12);

        // Corrupted data, then sequence resumes
        send("err_w", 1'b1, 1'b1, BASE + 48'd12, 64'hDEAD);
        wait_b("err_b", 2'b10);
        chk("err_flag", 64'(error_flag), 64'd1);
        chk("err_count", 64'(error_count), 64'd1);
        send("after_err_w", 1'b1, 1'b1, BASE + 48'd13, 64'd13);
        wait_b("after_err_b", 2'b00);
        chk("after_err_count", 64'(error_count), 64'd1);
        chk("after_err_wcount", 64'(write_count), 64'd14);

        // Read with R held while a write runs alongside
        bus.s_axi_rready  = 1'b0;
        bus.s_axi_araddr  = 48'h1234;
        bus.s_axi_arvalid = 1'b1;
        begin
            bit hs = 1'b0;
            int n  = 0;
            while (!hs && n < 20) begin
                @(negedge clk);
                hs = bus.s_axi_arready;
                @(posedge clk);
                #1;
                n++;
            end
            bus.s_axi_arvalid = 1'b0;
            if (!hs) timeout("ar_hs");
        end
        fork
            begin
                send("rd_par_w", 1'b1, 1'b1, BASE + 48'd14, 64'd14);
                wait_b("rd_par_b", 2'b00);
            end
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("rd_rvalid", 64'(bus.s_axi_rvalid), 64'd1);
                    chk("rd_rdata", bus.s_axi_rdata, 64'h1234);
                    chk("rd_arready", 64'(bus.s_axi_arready), 64'd0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        chk("rd_rresp", 64'(bus.s_axi_rresp), 64'd0);
        chk("rd_rvalid_hold", 64'(bus.s_axi_rvalid), 64'd1);
        bus.s_axi_rready = 1'b1;
        @(posedge clk);
        #1;
        chk("rd_rvalid_clr", 64'(bus.s_axi_rvalid), 64'd0);
        chk("rd_wcount", 64'(write_count), 64'd15);

        // Reset with B pending and AW parked
        bus.s_axi_bready = 1'b0;
        send("rst_mid_w", 1'b1, 1'b1, BASE + 48'd15, 64'd15);
        wait_b("rst_mid_b", 2'b00);
        send("rst_mid_aw", 1'b1, 1'b0, BASE + 48'd16, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_bvalid", 64'(bus.s_axi_bvalid), 64'd0);
        chk("mid_rst_rvalid", 64'(bus.s_axi_rvalid), 64'd0);
        chk("mid_rst_awready", 64'(bus.s_axi_awready), 64'd0);
        chk("mid_rst_wcount", 64'(write_count), 64'd0);
        chk("mid_rst_ecount", 64'(error_count), 64'd0);
        chk("mid_rst_eflag", 64'(error_flag), 64'd0);
        rst = 1'b0;
        bus.s_axi_bready = 1'b1;
        send("post_rst_w", 1'b1, 1'b1, BASE, 64'd0);
        wait_b("post_rst_b", 2'b00);
        chk("post_rst_wcount", 64'(write_count), 64'd1);
        chk("post_rst_ecount", 64'(error_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
